// File: rtl/dwt_subband_buffer.sv
// dwt_subband_buffer: pairs independently strobed L/H lifting outputs into an aligned valid/ready stream with frame marking
module dwt_subband_buffer #(
  parameter int SIZE        = 32,
  parameter int DEPTH       = 8,
  parameter int FRAME_PAIRS = 16,
  parameter int LW          = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            l_valid,
  input  logic [SIZE-1:0] l_data,
  input  logic            h_valid,
  input  logic [SIZE-1:0] h_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_l,
  output logic [SIZE-1:0] out_h,
  output logic            out_last,
  output logic [LW-1:0]   l_level,
  output logic [LW-1:0]   h_level,
  output logic            overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = FRAME_PAIRS > 1 ? $clog2(FRAME_PAIRS) : 1;
  logic [SIZE-1:0] l_mem [DEPTH];
  logic [SIZE-1:0] h_mem [DEPTH];
  logic [PW-1:0] l_wr_q, l_wr_d, l_rd_q, l_rd_d;
  logic [PW-1:0] h_wr_q, h_wr_d, h_rd_q, h_rd_d;
  logic [LW-1:0] l_level_q, l_level_d, h_level_q, h_level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic pop, l_push, h_push;
  assign out_valid = (l_level_q != '0) && (h_level_q != '0);
  assign out_l     = out_valid ? l_mem[l_rd_q] : '0;
  assign out_h     = out_valid ? h_mem[h_rd_q] : '0;
  assign out_last  = out_valid && (cnt_q == CW'(FRAME_PAIRS - 1));
  assign l_level   = l_level_q;
  assign h_level   = h_level_q;
  assign overflow  = ovf_q;
  assign pop       = out_valid && out_ready;
  // a full FIFO still accepts a write when the same edge frees a slot
  assign l_push    = l_valid && ((l_level_q != LW'(DEPTH)) || pop);
  assign h_push    = h_valid && ((h_level_q != LW'(DEPTH)) || pop);
  always_comb begin
    l_wr_d    = l_wr_q + PW'(l_push);
    h_wr_d    = h_wr_q + PW'(h_push);
    l_rd_d    = l_rd_q + PW'(pop);
    h_rd_d    = h_rd_q + PW'(pop);
    l_level_d = l_level_q + LW'(l_push) - LW'(pop);
    h_level_d = h_level_q + LW'(h_push) - LW'(pop);
    cnt_d     = pop ? (out_last ? '0 : cnt_q + 1'b1) : cnt_q;
    ovf_d     = ovf_q | (l_valid & ~l_push) | (h_valid & ~h_push);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_wr_q    <= '0;
      l_rd_q    <= '0;
      h_wr_q    <= '0;
      h_rd_q    <= '0;
      l_level_q <= '0;
      h_level_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      l_wr_q    <= l_wr_d;
      l_rd_q    <= l_rd_d;
      h_wr_q    <= h_wr_d;
      h_rd_q    <= h_rd_d;
      l_level_q <= l_level_d;
      h_level_q <= h_level_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
    end
  end
  // storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (l_push) l_mem[l_wr_q] <= l_data;
    if (h_push) h_mem[h_wr_q] <= h_data;
  end
endmodule

// File: tb/tb_dwt_subband_buffer.sv
// tb_dwt_subband_buffer: vector table, directed corner sequences and random traffic against a queue-based model
module tb_dwt_subband_buffer;
  localparam int SIZE = 32, DEPTH = 8, FP = 4, LW = 4;
  logic clk = 1'b0, rst_n = 1'b0, l_valid = 1'b0, h_valid = 1'b0, out_ready = 1'b0;
  logic [SIZE-1:0] l_data = '0, h_data = '0;
  logic out_valid, out_last, overflow;
  logic [SIZE-1:0] out_l, out_h;
  logic [LW-1:0] l_level, h_level;
  always #5 clk = ~clk;
  dwt_subband_buffer #(.SIZE(SIZE), .DEPTH(DEPTH), .FRAME_PAIRS(FP), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .l_valid(l_valid), .l_data(l_data), .h_valid(h_valid), .h_data(h_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_l(out_l), .out_h(out_h), .out_last(out_last),
    .l_level(l_level), .h_level(h_level), .overflow(overflow)
  );
  int total = 0, bad = 0;
  logic [31:0] lq[$], hq[$];
  int cnt, dut_pops;
  logic ovf;
  logic [31:0] dut_mask;
  typedef struct {
    logic lv; logic [31:0] ld; logic hv; logic [31:0] hd; logic rdy;
    logic ev; logic [31:0] el; logic [31:0] eh; logic elast; logic [3:0] ell; logic [3:0] ehl;
  } vec_t;
  vec_t tbl [9];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic model_reset();
    lq.delete(); hq.delete();
    cnt = 0; ovf = 1'b0; dut_pops = 0; dut_mask = '0;
  endtask
  task automatic drive_chk(input logic lv, input logic [31:0] ld, input logic hv, input logic [31:0] hd, input logic rdy);
    logic mv;
    l_valid = lv; l_data = ld; h_valid = hv; h_data = hd; out_ready = rdy;
    #1;
    mv = (lq.size() != 0) && (hq.size() != 0);
    chk("out_valid", 64'(out_valid), 64'(mv));
    chk("out_l", 64'(out_l), mv ? 64'(lq[0]) : 64'd0);
    chk("out_h", 64'(out_h), mv ? 64'(hq[0]) : 64'd0);
    chk("out_last", 64'(out_last), 64'(mv && cnt == FP - 1));
    chk("l_level", 64'(l_level), 64'(lq.size()));
    chk("h_level", 64'(h_level), 64'(hq.size()));
    chk("overflow", 64'(overflow), 64'(ovf));
    if (out_valid && rdy) begin
      if (out_last && dut_pops < 32) dut_mask[dut_pops] = 1'b1;
      dut_pops++;
    end
  endtask
  task automatic advance();
    logic pop;
    @(posedge clk);
    pop = (lq.size() != 0) && (hq.size() != 0) && out_ready;
    if (l_valid) begin
      if (lq.size() < DEPTH || pop) lq.push_back(l_data); else ovf = 1'b1;
    end
    if (h_valid) begin
      if (hq.size() < DEPTH || pop) hq.push_back(h_data); else ovf = 1'b1;
    end
    if (pop) begin
      void'(lq.pop_front());
      void'(hq.pop_front());
      cnt = (cnt == FP - 1) ? 0 : cnt + 1;
    end
    @(negedge clk);
  endtask
  task automatic cyc(input logic lv, input logic [31:0] ld, input logic hv, input logic [31:0] hd, input logic rdy);
    drive_chk(lv, ld, hv, hd, rdy);
    advance();
  endtask
  task automatic do_reset();
    l_valid = 1'b0; h_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_levels", 64'({l_level, h_level}), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_out_data", 64'({out_l, out_h}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    int p0, hold, idx;
    logic r, lv;
    tbl[0] = '{1'b1, 32'h11, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  32'h0,  1'b0, 4'd0, 4'd0};
    tbl[1] = '{1'b1, 32'h22, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  32'h0,  1'b0, 4'd1, 4'd0};
    tbl[2] = '{1'b1, 32'h33, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  32'h0,  1'b0, 4'd2, 4'd0};
    tbl[3] = '{1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  32'h0,  1'b0, 4'd3, 4'd0};
    tbl[4] = '{1'b0, 32'h0,  1'b1, 32'hA1, 1'b1, 1'b0, 32'h0,  32'h0,  1'b0, 4'd3, 4'd0};
    tbl[5] = '{1'b0, 32'h0,  1'b1, 32'hA2, 1'b1, 1'b1, 32'h11, 32'hA1, 1'b0, 4'd3, 4'd1};
    tbl[6] = '{1'b0, 32'h0,  1'b1, 32'hA3, 1'b1, 1'b1, 32'h22, 32'hA2, 1'b0, 4'd2, 4'd1};
    tbl[7] = '{1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b1, 32'h33, 32'hA3, 1'b0, 4'd1, 4'd1};
    tbl[8] = '{1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  32'h0,  1'b0, 4'd0, 4'd0};
    @(negedge clk);
    do_reset();
    repeat (10) cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      drive_chk(tbl[i].lv, tbl[i].ld, tbl[i].hv, tbl[i].hd, tbl[i].rdy);
      chk("skew_valid", 64'(out_valid), 64'(tbl[i].ev));
      chk("skew_l", 64'(out_l), 64'(tbl[i].el));
      chk("skew_h", 64'(out_h), 64'(tbl[i].eh));
      chk("skew_last", 64'(out_last), 64'(tbl[i].elast));
      chk("skew_l_level", 64'(l_level), 64'(tbl[i].ell));
      chk("skew_h_level", 64'(h_level), 64'(tbl[i].ehl));
      advance();
    end
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h100 + i, 1'b1, 32'h200 + i, 1'b0);
    cyc(1'b1, 32'h1FF, 1'b0, 32'h0, 1'b0);
    chk("bp_l_level", 64'(l_level), 64'd8);
    chk("bp_h_level", 64'(h_level), 64'd8);
    chk("bp_overflow", 64'(overflow), 64'd1);
    repeat (20) cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("bp_overflow_sticky", 64'(overflow), 64'd1);
    p0 = dut_pops;
    for (int i = 0; i < 8; i++) begin
      drive_chk(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("bp_order_l", 64'(out_l), 64'(32'h100 + i));
      chk("bp_order_h", 64'(out_h), 64'(32'h200 + i));
      advance();
    end
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("bp_drain_count", 64'(dut_pops - p0), 64'd8);
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h400 + i, 1'b1, 32'h500 + i, 1'b0);
    cyc(1'b1, 32'h99, 1'b1, 32'h9A, 1'b1);
    chk("pp_l_level", 64'(l_level), 64'd8);
    chk("pp_h_level", 64'(h_level), 64'd8);
    chk("pp_overflow", 64'(overflow), 64'd0);
    for (int i = 0; i < 8; i++) begin
      drive_chk(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("pp_pair_l", 64'(out_l), i == 7 ? 64'h99 : 64'(32'h401 + i));
      chk("pp_pair_h", 64'(out_h), i == 7 ? 64'h9A : 64'(32'h501 + i));
      advance();
    end
    do_reset();
    hold = 0; idx = 0;
    for (int c = 0; c < 60 && dut_pops < 10; c++) begin
      r = !(dut_pops == 7 && out_valid && hold < 3);
      if (!r) hold++;
      lv = idx < 10;
      drive_chk(lv, 32'h300 + idx, lv, 32'h600 + idx, r);
      if (!r) begin
        chk("hold_l", 64'(out_l), 64'h307);
        chk("hold_h", 64'(out_h), 64'h607);
        chk("hold_last", 64'(out_last), 64'd1);
      end
      advance();
      if (lv) idx++;
    end
    chk("frame_pops", 64'(dut_pops), 64'd10);
    chk("frame_hold_cycles", 64'(hold), 64'd3);
    chk("frame_last_mask", 64'(dut_mask & 32'h3FF), 64'h88);
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h700 + i, 1'b1, 32'h800 + i, 1'b0);
    repeat (2) cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    out_ready = 1'b0;
    #1;
    chk("mf_buffered", 64'(l_level), 64'd3);
    chk("mf_head", 64'(out_l), 64'h702);
    #1 rst_n = 1'b0;
    #1;
    chk("mf_valid_drop", 64'(out_valid), 64'd0);
    chk("mf_level_clear", 64'({l_level, h_level}), 64'd0);
    #1 rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h900 + i, 1'b1, 32'hA00 + i, 1'b1);
    repeat (3) cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("mf_pops", 64'(dut_pops), 64'd4);
    chk("mf_last_mask", 64'(dut_mask), 64'h8);
    do_reset();
    repeat (1500)
      cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
